// File: rtl/fwd_hazard_unit.sv
// ----------------------------------------------------------------------------
// fwd_hazard_unit
//
// Operand forwarding, pipeline stall generation and multi-cycle unit (MDU)
// tracking for an in-order pipeline.
//
// Parameters
//   AW       register-address width
//   NRD      number of source-operand ports (port k at bits [k*AW +: AW])
//   MDU_LAT  MDU latency from issue to write-back, legal range 2..15
//   CNT_W    width of the saturating stall counter
//
// Ports
//   clk, rst_n        clock; synchronous active-low reset
//   id_rs_flat        source registers of the instruction in ID
//   id_mdu_op         ID instruction is an MDU op
//   ex_rs_flat        source registers of the instruction in EX
//   idex_rd           EX destination register
//   idex_memread      EX instruction is a load
//   mdu_issue         EX instruction starts an MDU op targeting idex_rd
//   exmem_rd/_regwrite, memwb_rd/_regwrite   later-stage write-back info
//   stat_clr          synchronous clear of stall_cnt
//   fwd_sel_flat      per-port operand source: 00 RF, 10 EXMEM, 01 MEMWB,
//                     11 MDU result
//   stall             hold PC/IFID, bubble into IDEX
//   mdu_busy          MDU op in flight
//   mdu_done          one-cycle MDU write-back pulse
//   mdu_rd_q          MDU destination register
//   mdu_err           sticky: issue attempted while busy
//   stall_cnt         saturating count of stall cycles
// ----------------------------------------------------------------------------
module fwd_hazard_unit #(
    parameter int unsigned AW      = 5,
    parameter int unsigned NRD     = 2,
    parameter int unsigned MDU_LAT = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   id_rs_flat,
    input  logic                id_mdu_op,
    input  logic [NRD*AW-1:0]   ex_rs_flat,
    input  logic [AW-1:0]       idex_rd,
    input  logic                idex_memread,
    input  logic                mdu_issue,
    input  logic [AW-1:0]       exmem_rd,
    input  logic                exmem_regwrite,
    input  logic [AW-1:0]       memwb_rd,
    input  logic                memwb_regwrite,
    input  logic                stat_clr,
    output logic [NRD*2-1:0]    fwd_sel_flat,
    output logic                stall,
    output logic                mdu_busy,
    output logic                mdu_done,
    output logic [AW-1:0]       mdu_rd_q,
    output logic                mdu_err,
    output logic [CNT_W-1:0]    stall_cnt
);

    // Reload value for the MDU down-counter; the counter is 4 bits wide,
    // which covers the full legal latency range.
    localparam logic [3:0] LAT_RELOAD = 4'(MDU_LAT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mduState_t;

    mduState_t   state;
    mduState_t   stateNext;
    logic [3:0]  cnt;
    logic [3:0]  cntNext;
    logic [AW-1:0] rdNext;
    logic        doneNext;
    logic        errNext;

    // Per-port match vectors, kept as named signals for visibility.
    logic [NRD-1:0] exmemHit;
    logic [NRD-1:0] memwbHit;
    logic [NRD-1:0] mduHit;
    logic [NRD-1:0] idLoadHit;
    logic [NRD-1:0] idBusyHit;

    logic exmemValid;
    logic memwbValid;
    logic mduFwdValid;
    logic idexRdValid;
    logic mduRdValid;

    logic loadUse;
    logic issueRaw;
    logic busyRaw;
    logic structural;

    // ------------------------------------------------------------------
    // MDU tracker
    // ------------------------------------------------------------------
    assign mdu_busy = (state == BUSY);

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        rdNext    = mdu_rd_q;
        doneNext  = 1'b0;
        errNext   = mdu_err;

        case (state)
            IDLE: begin
                // Also covers the write-back cycle of a previous op, which
                // allows back-to-back issue.
                if (mdu_issue) begin
                    stateNext = BUSY;
                    cntNext   = LAT_RELOAD;
                    rdNext    = idex_rd;
                end
            end
            BUSY: begin
                // An issue while busy is dropped; only the error flag moves.
                if (mdu_issue) begin
                    errNext = 1'b1;
                end
                if (cnt > 4'd1) begin
                    cntNext = cnt - 4'd1;
                end else begin
                    stateNext = IDLE;
                    cntNext   = '0;
                    doneNext  = 1'b1;
                end
            end
            default: begin
                stateNext = IDLE;
                cntNext   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            mdu_rd_q <= '0;
            mdu_done <= 1'b0;
            mdu_err  <= 1'b0;
        end else begin
            state    <= stateNext;
            cnt      <= cntNext;
            mdu_rd_q <= rdNext;
            mdu_done <= doneNext;
            mdu_err  <= errNext;
        end
    end

    // ------------------------------------------------------------------
    // Forwarding select (EX operands)
    // ------------------------------------------------------------------
    // Register 0 is hard-wired, so a zero destination never matches.
    assign exmemValid  = exmem_regwrite && (exmem_rd != '0);
    assign memwbValid  = memwb_regwrite && (memwb_rd != '0);
    assign mduFwdValid = mdu_done && (mdu_rd_q != '0);

    always_comb begin
        exmemHit     = '0;
        memwbHit     = '0;
        mduHit       = '0;
        fwd_sel_flat = '0;
        for (int unsigned k = 0; k < NRD; k++) begin
            exmemHit[k] = exmemValid  && (exmem_rd == ex_rs_flat[k*AW +: AW]);
            memwbHit[k] = memwbValid  && (memwb_rd == ex_rs_flat[k*AW +: AW]);
            mduHit[k]   = mduFwdValid && (mdu_rd_q == ex_rs_flat[k*AW +: AW]);
            if (!rst_n) begin
                fwd_sel_flat[k*2 +: 2] = 2'b00;
            end else if (exmemHit[k]) begin
                fwd_sel_flat[k*2 +: 2] = 2'b10;
            end else if (memwbHit[k]) begin
                fwd_sel_flat[k*2 +: 2] = 2'b01;
            end else if (mduHit[k]) begin
                fwd_sel_flat[k*2 +: 2] = 2'b11;
            end else begin
                fwd_sel_flat[k*2 +: 2] = 2'b00;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stall generation (ID operands)
    // ------------------------------------------------------------------
    assign idexRdValid = (idex_rd != '0);
    assign mduRdValid  = (mdu_rd_q != '0);

    always_comb begin
        idLoadHit = '0;
        idBusyHit = '0;
        for (int unsigned k = 0; k < NRD; k++) begin
            idLoadHit[k] = idexRdValid && (idex_rd  == id_rs_flat[k*AW +: AW]);
            idBusyHit[k] = mduRdValid  && (mdu_rd_q == id_rs_flat[k*AW +: AW]);
        end
    end

    assign loadUse    = idex_memread && (|idLoadHit);
    assign issueRaw   = mdu_issue    && (|idLoadHit);
    assign busyRaw    = mdu_busy     && (|idBusyHit);
    assign structural = id_mdu_op    && (mdu_busy || mdu_issue);

    assign stall = rst_n && (loadUse || issueRaw || busyRaw || structural);

    // ------------------------------------------------------------------
    // Stall statistics
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n || stat_clr) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 Parameter AW, default 5: register-address width.
REQ-002 Parameter NRD, default 2: number of source-operand ports; port k uses bits [k*AW +: AW] of flat buses.
REQ-003 Parameter MDU_LAT, default 4, legal 2..15: multi-cycle unit latency, in cycles from issue to write-back.
REQ-004 Parameter CNT_W, default 16: stall-counter width.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  in  1  synchronous, active-low reset.
REQ-007 id_rs_flat  in  NRD*AW  source registers of the instruction in ID.
REQ-008 id_mdu_op  in  1  the ID instruction is a multi-cycle (MDU) op.
REQ-009 ex_rs_flat  in  NRD*AW  source registers of the instruction in EX (IDEX).
REQ-010 idex_rd, idex_memread  in  AW, 1  EX destination register; EX instruction is a load.
REQ-011 mdu_issue  in  1  the EX instruction starts an MDU op targeting idex_rd.
REQ-012 exmem_rd, exmem_regwrite, memwb_rd, memwb_regwrite  in  AW, 1, AW, 1  later-stage write info.
REQ-013 stat_clr  in  1  synchronous clear of stall_cnt.
REQ-014 fwd_sel_flat  out  NRD*2  per-port operand source: 00 register file, 10 EXMEM, 01 MEMWB, 11 MDU result.
REQ-015 stall  out  1  hold PC and IFID, insert a bubble into IDEX.
REQ-016 mdu_busy, mdu_done, mdu_rd_q  out  1, 1, AW  MDU in flight; one-cycle write-back pulse; MDU destination.
REQ-017 mdu_err  out  1  sticky flag: mdu_issue was asserted while mdu_busy.
REQ-018 stall_cnt  out  CNT_W  saturating count of stall cycles.

Function
REQ-019 Per port k, fwd_sel SHALL be combinational with priority: EXMEM (exmem_regwrite, exmem_rd≠0, exmem_rd==ex_rs[k]) -> 10; else MEMWB (same conditions) -> 01; else mdu_done && mdu_rd_q≠0 && mdu_rd_q==ex_rs[k] -> 11; else 00.
REQ-020 Register 0 SHALL never be a forwarding or stall match on any path.
REQ-021 stall SHALL be combinational and equal the OR of:
- load-use: idex_memread && idex_rd≠0 && any id_rs[k]==idex_rd;
- MDU issue RAW: mdu_issue && idex_rd≠0 && any id_rs[k]==idex_rd;
- MDU busy RAW: mdu_busy && mdu_rd_q≠0 && any id_rs[k]==mdu_rd_q;
- structural: id_mdu_op && (mdu_busy || mdu_issue).
REQ-022 MDU state machine SHALL have two states, IDLE and BUSY, with a down-counter cnt of width 4.
REQ-023 IDLE + mdu_issue: go to BUSY, cnt<=MDU_LAT-1, mdu_rd_q<=idex_rd.
REQ-024 BUSY with cnt>1: cnt<=cnt-1. BUSY with cnt==1: go to IDLE and register mdu_done=1 for the following cycle only.
REQ-025 Timing: for issue sampled at edge t, mdu_busy SHALL be 1 for cycles t+1..t+MDU_LAT-1 and mdu_done SHALL be 1 in cycle t+MDU_LAT, with mdu_rd_q held through that cycle.
REQ-026 An mdu_issue in the same cycle as mdu_done with mdu_busy=0 SHALL be accepted normally (back-to-back ops).
REQ-027 mdu_issue while mdu_busy SHALL be ignored (state unchanged) and SHALL set mdu_err, which stays set until reset.
REQ-028 stall_cnt SHALL increment each cycle stall=1 and saturate at all-ones. stat_clr SHALL zero it and takes priority over an increment in the same cycle.

Reset
REQ-029 While rst_n=0 at an edge, the block SHALL set state IDLE, cnt=0, mdu_busy=0, mdu_done=0, mdu_rd_q=0, mdu_err=0, stall_cnt=0.
REQ-030 While rst_n=0, stall and fwd_sel_flat SHALL be forced to 0.
REQ-031 A reset during BUSY SHALL abort the op; no mdu_done pulse SHALL follow.

Verification
REQ-032 Double hazard: exmem_rd=memwb_rd=ex_rs[0]=5, both regwrite=1 -> port0 sel=10. Then exmem_regwrite=0 -> sel=01. Then ex_rs[0]=0 -> sel=00.
REQ-033 Load-use: idex_memread=1, idex_rd=7, id_rs[1]=7 -> stall=1, stall_cnt +1. Then idex_rd=0 -> stall=0.
REQ-034 MDU timing: MDU_LAT=4, mdu_issue with idex_rd=9 at edge 0 -> busy in cycles 1-3, done in cycle 4 with mdu_rd_q=9. ex_rs[0]=9 in cycle 4 -> sel=11. id_rs=9 during cycles 1-3 -> stall=1.
REQ-035 Structural and error: id_mdu_op=1 while busy -> stall=1. Forced mdu_issue while busy -> mdu_err=1, mdu_rd_q unchanged, done timing of the first op unchanged.
REQ-036 Reset mid-op: rst_n=0 in cycle 2 of a 4-cycle op -> mdu_busy=0, no done pulse, stall_cnt=0.
REQ-037 Saturation: CNT_W=4, 20 stall cycles -> stall_cnt=15. stat_clr together with stall -> 0.
